// File: rtl/pipeline_issue_unit.sv
// pipeline_issue_unit: fetches instructions and feeds the four-stage pipe, with hold, branch redirect and a one-word skid buffer.
module pipeline_issue_unit #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [15:0] BUBBLE_INST = 16'h001F,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_rd,
    output logic [15:0]      imem_addr,
    input  logic [15:0]      imem_rdata,
    input  logic             hold_in,
    input  logic             pc_enable,
    input  logic             br_taken,
    input  logic [15:0]      br_target,
    output logic [15:0]      inst_ipipe [1:4],
    output logic [4:0]       opcode [1:4],
    output logic [3:0]       stage_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef enum logic [1:0] {S_START, S_RUN, S_HOLD, S_REDIR} state_t;
    state_t      state;
    logic [15:0] fetch_pc;
    logic [15:0] skid;
    logic        skid_full;
    logic        pending;
    assign imem_addr = fetch_pc;
    // no fetch in a flush cycle, so nothing from the old path is ever in flight after redirect
    assign imem_rd = (state == S_RUN || state == S_REDIR) && pc_enable && !skid_full && !hold_in && !br_taken;
    for (genvar i = 1; i <= 4; i++) begin : g_op
        assign opcode[i] = inst_ipipe[i][4:0];
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_START;
            fetch_pc    <= RESET_PC;
            skid        <= BUBBLE_INST;
            skid_full   <= 1'b0;
            pending     <= 1'b0;
            stage_valid <= '0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            for (int k = 1; k <= 4; k++) inst_ipipe[k] <= BUBBLE_INST;
        end else begin
            pending        <= imem_rd;
            inst_ipipe[4]  <= inst_ipipe[3];
            stage_valid[3] <= stage_valid[2];
            if (br_taken) begin
                state         <= S_REDIR;
                fetch_pc      <= br_target;
                skid_full     <= 1'b0;
                inst_ipipe[3] <= BUBBLE_INST;
                inst_ipipe[2] <= BUBBLE_INST;
                inst_ipipe[1] <= BUBBLE_INST;
                stage_valid[2:0] <= 3'b000;
                flush_cnt     <= flush_cnt + CNT_W'(~&flush_cnt);
            end else begin
                state <= (state == S_START || state == S_REDIR) ? S_RUN : (hold_in ? S_HOLD : S_RUN);
                if (imem_rd) fetch_pc <= fetch_pc + 16'd2;
                if (hold_in) begin
                    inst_ipipe[3]  <= BUBBLE_INST;
                    stage_valid[2] <= 1'b0;
                    stall_cnt      <= stall_cnt + CNT_W'(~&stall_cnt);
                    if (pending) begin
                        skid      <= imem_rdata;
                        skid_full <= 1'b1;
                    end
                end else begin
                    inst_ipipe[3]  <= inst_ipipe[2];
                    inst_ipipe[2]  <= inst_ipipe[1];
                    inst_ipipe[1]  <= skid_full ? skid : (pending ? imem_rdata : BUBBLE_INST);
                    stage_valid[2] <= stage_valid[1];
                    stage_valid[1] <= stage_valid[0];
                    stage_valid[0] <= skid_full || pending;
                    skid_full      <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_pipeline_issue_unit.sv
// tb_pipeline_issue_unit: directed stimulus; words expected at stage 4 are queued and checked by a separate monitor.
module tb_pipeline_issue_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = 16'h0000;
    logic        hold_in = 1'b0;
    logic        pc_enable = 1'b1;
    logic        br_taken = 1'b0;
    logic [15:0] br_target = 16'h0000;
    logic [15:0] inst_ipipe [1:4];
    logic [4:0]  opcode [1:4];
    logic [3:0]  stage_valid;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    pipeline_issue_unit dut (
        .clk(clk), .reset(reset), .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .hold_in(hold_in), .pc_enable(pc_enable), .br_taken(br_taken), .br_target(br_target),
        .inst_ipipe(inst_ipipe), .opcode(opcode), .stage_valid(stage_valid),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    function automatic logic [15:0] w(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    always @(posedge clk) if (imem_rd) imem_rdata <= w(imem_addr);

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic h, input logic pe, input logic br, input logic [15:0] t);
        @(negedge clk);
        hold_in = h;
        pc_enable = pe;
        br_taken = br;
        br_target = t;
        #1;
    endtask

    task automatic fetch(input string name, input logic rd, input logic [15:0] a);
        check({name, "_rd"}, {15'b0, imem_rd}, {15'b0, rd});
        if (rd) check({name, "_addr"}, imem_addr, a);
    endtask

    task automatic check_reset_state(input string name);
        for (int k = 1; k <= 4; k++) check({name, "_stage"}, inst_ipipe[k], 16'h001F);
        check({name, "_valid"}, {12'b0, stage_valid}, 16'h0000);
        check({name, "_stall"}, stall_cnt, 16'h0000);
        check({name, "_flush"}, flush_cnt, 16'h0000);
        check({name, "_rd"}, {15'b0, imem_rd}, 16'h0000);
    endtask

    always @(posedge clk) begin : monitor
        logic [15:0] e;
        #1;
        if (stage_valid[3]) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stage4_unexpected actual=%h expected=none", inst_ipipe[4]);
            end else begin
                e = exp_q.pop_front();
                check("stage4", inst_ipipe[4], e);
                check("opcode4", {11'b0, opcode[4]}, {11'b0, e[4:0]});
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check_reset_state("reset");
        exp_q.push_back(w(16'h0000));
        exp_q.push_back(w(16'h0002));
        @(negedge clk);
        reset = 1'b0;
        #1;
        fetch("start", 1'b0, 16'h0000);
        cyc(0, 1, 0, 0); fetch("f0", 1'b1, 16'h0000);
        cyc(0, 1, 0, 0); fetch("f2", 1'b1, 16'h0002);
        cyc(0, 1, 0, 0); fetch("f4", 1'b1, 16'h0004);
        cyc(0, 1, 0, 0); fetch("f6", 1'b1, 16'h0006);
        // two hold cycles with B in stage 2; D lands in the skid
        cyc(1, 1, 0, 0); fetch("hold1", 1'b0, 16'h0000);
        cyc(1, 1, 0, 0); fetch("hold2", 1'b0, 16'h0000);
        cyc(0, 1, 0, 0); fetch("hold_exit", 1'b0, 16'h0000);
        check("stall_after_hold", stall_cnt, 16'd2);
        check("valid_after_hold", {12'b0, stage_valid}, 16'h0003);
        check("stage2_b", inst_ipipe[2], w(16'h0002));
        check("stage1_c", inst_ipipe[1], w(16'h0004));
        cyc(0, 1, 1, 16'h0040);
        check("stage2_c", inst_ipipe[2], w(16'h0004));
        check("stage1_d", inst_ipipe[1], w(16'h0006));
        fetch("br_cycle", 1'b0, 16'h0000);
        cyc(0, 1, 0, 0);
        check("flush1", flush_cnt, 16'd1);
        check("valid_after_flush", {12'b0, stage_valid}, 16'h0008);
        fetch("redir1", 1'b1, 16'h0040);
        cyc(0, 1, 0, 0); fetch("f42", 1'b1, 16'h0042);
        // flush and hold together: flush wins, stall count untouched
        cyc(1, 1, 1, 16'h0080); fetch("br_hold", 1'b0, 16'h0000);
        cyc(0, 1, 0, 0);
        check("stall_unchanged", stall_cnt, 16'd2);
        check("flush2", flush_cnt, 16'd2);
        check("valid_after_flush2", {12'b0, stage_valid}, 16'h0000);
        fetch("redir2", 1'b1, 16'h0080);
        exp_q.push_back(w(16'h0080));
        exp_q.push_back(w(16'h0082));
        exp_q.push_back(w(16'h0084));
        exp_q.push_back(w(16'h0086));
        cyc(0, 1, 0, 0); fetch("f82", 1'b1, 16'h0082);
        cyc(0, 1, 0, 0); fetch("f84", 1'b1, 16'h0084);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0);
            fetch("pe_off", 1'b0, 16'h0000);
            check("pe_off_pc", imem_addr, 16'h0086);
        end
        cyc(0, 1, 0, 0); fetch("f86", 1'b1, 16'h0086);
        repeat (6) cyc(0, 0, 0, 0);
        check("drain1", 16'(exp_q.size()), 16'd0);
        exp_q.push_back(w(16'hFFFE));
        exp_q.push_back(w(16'h0000));
        cyc(0, 1, 1, 16'hFFFE); fetch("br_wrap", 1'b0, 16'h0000);
        cyc(0, 1, 0, 0); fetch("wrap_fffe", 1'b1, 16'hFFFE);
        cyc(0, 1, 0, 0); fetch("wrap_0000", 1'b1, 16'h0000);
        cyc(0, 0, 0, 0); check("wrap_pc", imem_addr, 16'h0002);
        repeat (5) cyc(0, 0, 0, 0);
        check("drain2", 16'(exp_q.size()), 16'd0);
        // fill the skid, then reset asynchronously mid-cycle
        cyc(0, 1, 0, 0); fetch("pre_skid", 1'b1, 16'h0002);
        cyc(1, 1, 0, 0); fetch("skid_hold", 1'b0, 16'h0000);
        @(negedge clk);
        hold_in = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("mid_reset");
        exp_q.push_back(w(16'h0000));
        @(negedge clk);
        reset = 1'b0;
        pc_enable = 1'b1;
        #1;
        fetch("rst2_start", 1'b0, 16'h0000);
        cyc(0, 1, 0, 0); fetch("rst2_f0", 1'b1, 16'h0000);
        repeat (6) cyc(0, 0, 0, 0);
        check("drain3", 16'(exp_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
